// File: rtl/fp_int_convert_pipe.sv
// Three-stage pipelined IEEE-754 single <-> INT_W-bit integer converter with
// RNE/RTZ rounding, F2I saturation and inexact/invalid flags.
module fp_int_convert_pipe #(
  parameter int unsigned INT_W = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_rm,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inexact,
  output logic             out_invalid
);

  localparam int unsigned LZ_W = 6;
  // Range limits as magnitudes; the saturated pattern equals the violated limit.
  localparam logic [33:0] MAX_U   = 34'((64'd1 << INT_W) - 64'd1);
  localparam logic [33:0] MAX_S   = 34'((64'd1 << (INT_W - 1)) - 64'd1);
  localparam logic [33:0] MIN_S   = 34'(64'd1 << (INT_W - 1));
  localparam logic [31:0] HI_MASK = ~32'((64'd1 << INT_W) - 64'd1);

  typedef struct packed {
    logic [1:0]       op;
    logic             rm;
    logic [TAG_W-1:0] tag;
    logic             sign;
    logic             nan;
    logic [7:0]       exp;
    logic [31:0]      mag;
    logic [LZ_W-1:0]  lz;
  } s1_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             rm;
    logic [TAG_W-1:0] tag;
    logic             sign;
    logic             nan;
    logic             big;
    logic             zero;
    logic [32:0]      ival;
    logic             guard;
    logic             sticky;
    logic [7:0]       exp;
  } s2_t;

  function automatic logic [LZ_W-1:0] clz(input logic [INT_W-1:0] v);
    clz = LZ_W'(INT_W);
    for (int i = 0; i < int'(INT_W); i++) begin
      if (v[i]) clz = LZ_W'(int'(INT_W) - 1 - i);
    end
  endfunction

  logic adv;
  logic v1, v2;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: unpack float fields, or integer magnitude plus leading-zero count
  logic [INT_W-1:0] i_raw, i_mag;
  logic             i_neg;

  always_comb begin
    i_raw = in_data[INT_W-1:0];
    i_neg = !in_op[0] && i_raw[INT_W-1];
    i_mag = i_neg ? (~i_raw + INT_W'(1)) : i_raw;
    s1_d      = '0;
    s1_d.op   = in_op;
    s1_d.rm   = in_rm;
    s1_d.tag  = in_tag;
    if (!in_op[1]) begin
      s1_d.sign = in_data[31];
      s1_d.exp  = in_data[30:23];
      s1_d.mag  = {8'd0, (in_data[30:23] != 8'd0), in_data[22:0]};
      s1_d.nan  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    end else begin
      s1_d.sign = i_neg;
      s1_d.mag  = 32'(i_mag);
      s1_d.lz   = clz(i_mag);
    end
  end

  // S2: align to the integer binary point, or normalise the MSB to bit 31
  logic [8:0]      exp_eff, lsh, rsh;
  logic [48:0]     wide;
  logic [LZ_W-1:0] nsh;

  always_comb begin
    exp_eff = (s1_q.exp == 8'd0) ? 9'd1 : {1'b0, s1_q.exp};
    lsh     = exp_eff - 9'd150;
    rsh     = 9'd150 - exp_eff;
    // Shifting past 25 only moves bits deeper into sticky, so clamp there.
    wide    = {s1_q.mag[23:0], 25'd0} >> ((rsh > 9'd25) ? 9'd25 : rsh);
    nsh     = s1_q.lz + LZ_W'(32 - INT_W);
    s2_d      = '0;
    s2_d.op   = s1_q.op;
    s2_d.rm   = s1_q.rm;
    s2_d.tag  = s1_q.tag;
    s2_d.sign = s1_q.sign;
    s2_d.nan  = s1_q.nan;
    if (!s1_q.op[1]) begin
      if (exp_eff >= 9'd150) begin
        // Beyond 2^33 every integer width overflows; Inf/NaN land here too.
        s2_d.big  = lsh > 9'd9;
        s2_d.ival = 33'(s1_q.mag[23:0]) << lsh[3:0];
      end else begin
        s2_d.ival   = 33'(wide[48:25]);
        s2_d.guard  = wide[24];
        s2_d.sticky = |wide[23:0];
      end
    end else begin
      s2_d.zero = (s1_q.mag == 32'd0);
      s2_d.ival = {1'b0, s1_q.mag << nsh};
      s2_d.exp  = 8'd127 + 8'(INT_W - 1) - {2'b00, s1_q.lz};
    end
  end

  // S3: round, saturate and pack
  logic             f_inc, i_inc, i_guard, i_sticky;
  logic [33:0]      rnd, lim;
  logic [INT_W-1:0] res_w;
  logic [24:0]      fsum;
  logic [22:0]      frac;
  logic [7:0]       fexp;
  logic [31:0]      res_d;
  logic             inx_d, inv_d;

  always_comb begin
    f_inc    = !s2_q.rm && s2_q.guard && (s2_q.sticky || s2_q.ival[0]);
    rnd      = 34'(s2_q.ival) + 34'(f_inc);
    if (s2_q.op[0]) lim = s2_q.sign ? 34'd0 : MAX_U;
    else            lim = s2_q.sign ? MIN_S : MAX_S;
    i_guard  = s2_q.ival[7];
    i_sticky = |s2_q.ival[6:0];
    i_inc    = !s2_q.rm && i_guard && (i_sticky || s2_q.ival[8]);
    fsum     = {1'b0, s2_q.ival[31:8]} + 25'(i_inc);
    frac     = fsum[24] ? fsum[23:1] : fsum[22:0];
    fexp     = s2_q.exp + 8'(fsum[24]);
    res_w    = INT_W'(s2_q.sign ? (~rnd + 34'd1) : rnd);
    res_d    = '0;
    inx_d    = 1'b0;
    inv_d    = 1'b0;
    if (!s2_q.op[1]) begin
      if (s2_q.nan) begin
        res_w = '0;
        inv_d = 1'b1;
      end else if (s2_q.big || (rnd > lim)) begin
        res_w = INT_W'(lim);
        inv_d = 1'b1;
      end else begin
        inx_d = s2_q.guard || s2_q.sticky;
      end
      res_d = 32'(res_w) | ((!s2_q.op[0] && res_w[INT_W-1]) ? HI_MASK : 32'd0);
    end else begin
      res_d = s2_q.zero ? 32'd0 : {s2_q.sign, fexp, frac};
      inx_d = i_guard || i_sticky;
    end
  end

  // Single global advance: every stage moves together or holds
  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_inexact <= 1'b0;
      out_invalid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      s1_q      <= s1_d;
      v2        <= v1;
      s2_q      <= s2_d;
      out_valid <= v2;
      if (v2) begin
        out_data    <= res_d;
        out_tag     <= s2_q.tag;
        out_inexact <= inx_d;
        out_invalid <= inv_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_int_convert_pipe.sv
// Directed-vector bench for fp_int_convert_pipe: 32- and 16-bit integer
// instances, random handshake stream drawn from the vector table, mid-flight reset.
module tb_fp_int_convert_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid16, out_ready;
  logic [1:0]  in_op;
  logic        in_rm;
  logic [31:0] in_data;
  logic [7:0]  in_tag;

  logic        in_ready, out_valid, out_inexact, out_invalid;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        in_ready16, out_valid16, out_inexact16, out_invalid16;
  logic [31:0] out_data16;
  logic [7:0]  out_tag16;

  always #5 clk = ~clk;

  fp_int_convert_pipe #(.INT_W(32), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rm(in_rm), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_inexact(out_inexact), .out_invalid(out_invalid)
  );

  fp_int_convert_pipe #(.INT_W(16), .TAG_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_op(in_op), .in_rm(in_rm), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_tag(out_tag16), .out_inexact(out_inexact16), .out_invalid(out_invalid16)
  );

  // exp = {inexact, invalid, data}
  typedef struct packed {
    logic [1:0]  op;
    logic        rm;
    logic [31:0] d;
    logic [33:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tag_ctr = 8'h01;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  localparam int NV = 23;

  function automatic vec_t get_vec(input int i);
    case (i)
      0:  get_vec = '{2'd0, 1'b0, 32'h41380000, {2'b10, 32'h0000000C}};
      1:  get_vec = '{2'd0, 1'b0, 32'hC0200000, {2'b10, 32'hFFFFFFFE}};
      2:  get_vec = '{2'd0, 1'b1, 32'h41380000, {2'b10, 32'h0000000B}};
      3:  get_vec = '{2'd0, 1'b0, 32'h4F32D05E, {2'b01, 32'h7FFFFFFF}};
      4:  get_vec = '{2'd1, 1'b0, 32'h4F32D05E, {2'b00, 32'hB2D05E00}};
      5:  get_vec = '{2'd1, 1'b0, 32'hBF800000, {2'b01, 32'h00000000}};
      6:  get_vec = '{2'd0, 1'b0, 32'h7FC00000, {2'b01, 32'h00000000}};
      7:  get_vec = '{2'd2, 1'b0, 32'h0000000A, {2'b00, 32'h41200000}};
      8:  get_vec = '{2'd2, 1'b0, 32'hFFFFFFFF, {2'b00, 32'hBF800000}};
      9:  get_vec = '{2'd3, 1'b0, 32'hFFFFFFFF, {2'b10, 32'h4F800000}};
      10: get_vec = '{2'd2, 1'b0, 32'h01000001, {2'b10, 32'h4B800000}};
      11: get_vec = '{2'd2, 1'b1, 32'h01000001, {2'b10, 32'h4B800000}};
      12: get_vec = '{2'd2, 1'b0, 32'h00000000, {2'b00, 32'h00000000}};
      13: get_vec = '{2'd0, 1'b0, 32'hFF800000, {2'b01, 32'h80000000}};
      14: get_vec = '{2'd0, 1'b0, 32'h80000000, {2'b00, 32'h00000000}};
      15: get_vec = '{2'd0, 1'b0, 32'h00000001, {2'b10, 32'h00000000}};
      16: get_vec = '{2'd1, 1'b0, 32'hBF000000, {2'b10, 32'h00000000}};
      17: get_vec = '{2'd0, 1'b0, 32'h3FC00000, {2'b10, 32'h00000002}};
      18: get_vec = '{2'd0, 1'b0, 32'hCF000000, {2'b00, 32'h80000000}};
      19: get_vec = '{2'd2, 1'b0, 32'h80000000, {2'b00, 32'hCF000000}};
      20: get_vec = '{2'd0, 1'b0, 32'h7F800000, {2'b01, 32'h7FFFFFFF}};
      21: get_vec = '{2'd2, 1'b0, 32'h01000003, {2'b10, 32'h4B800002}};
      default: get_vec = '{2'd2, 1'b1, 32'h01000003, {2'b10, 32'h4B800001}};
    endcase
  endfunction

  function automatic vec_t get_vec16(input int i);
    case (i)
      0:  get_vec16 = '{2'd0, 1'b0, 32'h47000000, {2'b01, 32'h00007FFF}};
      1:  get_vec16 = '{2'd2, 1'b0, 32'h00008000, {2'b00, 32'hC7000000}};
      2:  get_vec16 = '{2'd2, 1'b0, 32'hFFFF0005, {2'b00, 32'h40A00000}};
      3:  get_vec16 = '{2'd0, 1'b0, 32'hC7000000, {2'b00, 32'hFFFF8000}};
      default: get_vec16 = '{2'd1, 1'b0, 32'h47800000, {2'b01, 32'h0000FFFF}};
    endcase
  endfunction

  // One transaction into an idle pipe; result must show in the 3rd cycle counting the accept cycle
  task automatic run(input bit w16, input vec_t v, input string name);
    int  lat;
    bit  got;
    logic [33:0] obs;
    logic [7:0]  otag;
    @(negedge clk);
    in_op = v.op; in_rm = v.rm; in_data = v.d; in_tag = tag_ctr; out_ready = 1'b1;
    if (w16) in_valid16 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_valid16 = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (w16 ? out_valid16 : out_valid) got = 1'b1;
    end
    check_eq({name, "_lat"}, 64'(lat), 64'd3);
    obs  = w16 ? {out_inexact16, out_invalid16, out_data16} : {out_inexact, out_invalid, out_data};
    otag = w16 ? out_tag16 : out_tag;
    check_eq(name, 64'(obs), 64'(v.exp));
    check_eq({name, "_tag"}, 64'(otag), 64'(tag_ctr));
    tag_ctr++;
  endtask

  initial begin
    vec_t cur;
    logic [41:0] q_exp[$];
    logic [41:0] snap, front;
    bit   pending, stall_prev;
    int   sent, rcvd, stale;

    rst = 1'b1; in_valid = 1'b0; in_valid16 = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rm = 1'b0; in_data = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_state", 64'({out_valid, out_tag, out_inexact, out_invalid, out_data}), 64'd0);
    check_eq("rst_ready", 64'({in_ready, in_ready16}), 64'b11);
    check_eq("rst_valid16", 64'(out_valid16), 64'd0);

    for (int i = 0; i < NV; i++) run(1'b0, get_vec(i), $sformatf("v%0d", i));
    for (int i = 0; i < 5; i++) run(1'b1, get_vec16(i), $sformatf("w16_%0d", i));

    // Random stream with pseudo-random backpressure, expectations from the table
    sent = 0; rcvd = 0; pending = 1'b0; stall_prev = 1'b0; snap = '0; cur = get_vec(0);
    for (int cyc = 0; cyc < 600 && rcvd < 20; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!pending && sent < 20 && $urandom_range(0, 3) != 0) begin
        cur = get_vec(int'($urandom_range(0, NV - 1)));
        pending = 1'b1;
        in_op = cur.op; in_rm = cur.rm; in_data = cur.d; in_tag = 8'(8'd100 + 8'(sent));
      end
      in_valid = pending;
      #1;
      check_eq("rand_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (stall_prev)
        check_eq("rand_hold", 64'({out_tag, out_inexact, out_invalid, out_data}), 64'(snap));
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          check_eq("rand_spurious", 64'd1, 64'(q_exp.size()));
        end else begin
          front = q_exp.pop_front();
          check_eq($sformatf("rand_%0d", rcvd),
                   64'({out_tag, out_inexact, out_invalid, out_data}), 64'(front));
          rcvd++;
        end
      end
      stall_prev = out_valid && !out_ready;
      snap = {out_tag, out_inexact, out_invalid, out_data};
      if (in_valid && in_ready) begin
        q_exp.push_back({in_tag, cur.exp});
        sent++;
        pending = 1'b0;
      end
    end
    check_eq("rand_count", 64'(rcvd), 64'd20);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Fill the pipe under stall, then reset with three in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd2; in_rm = 1'b0;
      in_data = 32'(k + 1); in_tag = 8'(8'hE0 + 8'(k));
    end
    @(negedge clk);
    check_eq("full_valid", 64'(out_valid), 64'd1);
    check_eq("full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("midrst_stale", 64'(stale), 64'd0);
    run(1'b0, get_vec(7), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
